// File: rtl/motors_cmd_queue.sv
// Command FIFO between the instruction decoder and the motors controller.
// Buffers pen moves, drops null moves, and issues one command per trigger/done handshake.
module motors_cmd_queue #(
  parameter int unsigned PULSE_NUM_X_BITS = 16,
  parameter int unsigned PULSE_NUM_Y_BITS = 16,
  parameter int unsigned DEPTH            = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        flush,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [PULSE_NUM_X_BITS-1:0] cmd_pulse_x,
  input  logic [PULSE_NUM_Y_BITS-1:0] cmd_pulse_y,
  input  logic                        cmd_servo_down,
  output logic [PULSE_NUM_X_BITS-1:0] mot_pulse_num_x,
  output logic [PULSE_NUM_Y_BITS-1:0] mot_pulse_num_y,
  output logic                        mot_servo_down,
  output logic                        mot_trigger,
  input  logic                        mot_rdy,
  input  logic                        mot_done,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        busy,
  output logic [15:0]                 done_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PULSE_NUM_X_BITS + PULSE_NUM_Y_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]            level_q, level_d;
  logic [PULSE_NUM_X_BITS-1:0] mot_x_q, mot_x_d;
  logic [PULSE_NUM_Y_BITS-1:0] mot_y_q, mot_y_d;
  logic                        mot_servo_q, mot_servo_d;
  logic [15:0]                 done_count_q, done_count_d;

  logic [ENTRY_W-1:0]          mem [DEPTH];

  logic                        full;
  logic                        push;
  logic                        pop;
  logic [ENTRY_W-1:0]          head;
  logic [PULSE_NUM_X_BITS-1:0] head_x;
  logic [PULSE_NUM_Y_BITS-1:0] head_y;
  logic                        head_servo;
  logic                        head_null;

  assign full       = (level_q == LVL_W'(DEPTH));
  assign push       = clk_en & cmd_valid & ~full & ~flush;
  assign pop        = clk_en & ~flush & (state_q == S_IDLE) & (level_q != '0) & mot_rdy;
  assign head       = mem[rd_ptr_q];
  assign head_x     = head[ENTRY_W-1 -: PULSE_NUM_X_BITS];
  assign head_y     = head[PULSE_NUM_Y_BITS:1];
  assign head_servo = head[0];
  // A null move changes nothing mechanically, so it is consumed without a trigger.
  assign head_null  = (head_x == '0) && (head_y == '0) && (head_servo == mot_servo_q);

  // Storage array has no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_pulse_x, cmd_pulse_y, cmd_servo_down};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      mot_x_q      <= '0;
      mot_y_q      <= '0;
      mot_servo_q  <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      mot_x_q      <= mot_x_d;
      mot_y_q      <= mot_y_d;
      mot_servo_q  <= mot_servo_d;
      done_count_q <= done_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    mot_x_d      = mot_x_q;
    mot_y_d      = mot_y_q;
    mot_servo_d  = mot_servo_q;
    done_count_d = done_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    // Flush clears the queue only; an in-flight command runs to completion.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop && !head_null) begin
          mot_x_d     = head_x;
          mot_y_d     = head_y;
          mot_servo_d = head_servo;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (clk_en) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (clk_en && mot_done) begin
          state_d      = S_IDLE;
          done_count_d = done_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready       = ~full;
  assign level           = level_q;
  assign mot_trigger     = (state_q == S_ISSUE);
  assign busy            = (state_q != S_IDLE) || (level_q != '0);
  assign mot_pulse_num_x = mot_x_q;
  assign mot_pulse_num_y = mot_y_q;
  assign mot_servo_down  = mot_servo_q;
  assign done_count      = done_count_q;

endmodule

// File: tb/tb_motors_cmd_queue.sv
// Directed and randomized checks of motors_cmd_queue against a command-sequence model.
// A small controller responder answers triggers and logs every issued command.
module tb_motors_cmd_queue;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_pulse_x;
  logic [15:0] cmd_pulse_y;
  logic        cmd_servo_down;
  logic [15:0] mot_pulse_num_x;
  logic [15:0] mot_pulse_num_y;
  logic        mot_servo_down;
  logic        mot_trigger;
  logic        mot_rdy;
  logic        mot_done;
  logic [3:0]  level;
  logic        busy;
  logic [15:0] done_count;

  int n_checks = 0;
  int n_errors = 0;

  logic        resp_en    = 1'b0;
  logic        rdy_allow  = 1'b0;
  logic        man_rdy    = 1'b0;
  logic        man_done   = 1'b0;
  logic        r_done     = 1'b0;
  logic        ctl_busy   = 1'b0;
  logic        trig_prev  = 1'b0;
  int          resp_lat   = 1;
  int          ctl_wait   = 0;
  logic [15:0] dc_at_done = '0;
  cmd_t        mon_e;
  cmd_t        trig_log[$];

  motors_cmd_queue #(
    .PULSE_NUM_X_BITS(16),
    .PULSE_NUM_Y_BITS(16),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .flush(flush),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pulse_x(cmd_pulse_x),
    .cmd_pulse_y(cmd_pulse_y),
    .cmd_servo_down(cmd_servo_down),
    .mot_pulse_num_x(mot_pulse_num_x),
    .mot_pulse_num_y(mot_pulse_num_y),
    .mot_servo_down(mot_servo_down),
    .mot_trigger(mot_trigger),
    .mot_rdy(mot_rdy),
    .mot_done(mot_done),
    .level(level),
    .busy(busy),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  assign mot_rdy  = resp_en ? (rdy_allow && !ctl_busy) : man_rdy;
  assign mot_done = resp_en ? r_done : man_done;

  // Controller stand-in: logs each trigger, holds mot_done until the count moves.
  always @(posedge clk) begin
    #1;
    if (mot_trigger && !trig_prev) begin
      mon_e.x = mot_pulse_num_x;
      mon_e.y = mot_pulse_num_y;
      mon_e.s = mot_servo_down;
      trig_log.push_back(mon_e);
    end
    trig_prev = mot_trigger;
    if (resp_en) begin
      if (r_done && done_count != dc_at_done) begin
        r_done   = 1'b0;
        ctl_busy = 1'b0;
      end else if (!ctl_busy && mot_trigger) begin
        ctl_busy = 1'b1;
        ctl_wait = resp_lat;
      end else if (ctl_busy && !r_done) begin
        if (ctl_wait > 1) ctl_wait--;
        else begin
          r_done     = 1'b1;
          dc_at_done = done_count;
        end
      end
    end else begin
      r_done   = 1'b0;
      ctl_busy = 1'b0;
    end
  end

  function automatic cmd_t mk(input logic [15:0] x, input logic [15:0] y, input logic s);
    cmd_t e;
    e.x = x;
    e.y = y;
    e.s = s;
    return e;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_trig(input int idx, input cmd_t e);
    if (idx < trig_log.size()) chk("trig_cmd", 64'(trig_log[idx]), 64'(e));
    else chk("trig_missing", 64'(trig_log.size()), 64'(idx + 1));
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic s);
    cmd_pulse_x    = x;
    cmd_pulse_y    = y;
    cmd_servo_down = s;
    cmd_valid      = 1'b1;
    tick();
    cmd_valid      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while ((busy || ctl_busy) && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 64'(busy || ctl_busy), 64'(0));
  endtask

  task automatic man_cycle();
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  cmd_t        mq[$];
  cmd_t        exp_q[$];
  cmd_t        rc;
  logic        prev_s;
  logic [15:0] exp_dc;

  initial begin
    reset = 1'b0; clk_en = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
    cmd_pulse_x = '0; cmd_pulse_y = '0; cmd_servo_down = 1'b0;
    tick(3);
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_trig", 64'(mot_trigger), 64'(0));
    chk("rst_x", 64'(mot_pulse_num_x), 64'(0));
    chk("rst_y", 64'(mot_pulse_num_y), 64'(0));
    chk("rst_servo", 64'(mot_servo_down), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dc", 64'(done_count), 64'(0));
    reset = 1'b1; clk_en = 1'b1; resp_en = 1'b1; rdy_allow = 1'b1; resp_lat = 10;
    tick();

    // Single command round trip
    push(16'd100, 16'hFFCE, 1'b1);
    chk("t1_level", 64'(level), 64'(1));
    wait_idle("t1_idle", 100);
    chk("t1_ntrig", 64'(trig_log.size()), 64'(1));
    chk_trig(0, mk(16'd100, 16'hFFCE, 1'b1));
    chk("t1_x", 64'(mot_pulse_num_x), 64'(100));
    chk("t1_y", 64'(mot_pulse_num_y), 64'h0000_FFCE);
    chk("t1_servo", 64'(mot_servo_down), 64'(1));
    chk("t1_dc", 64'(done_count), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    exp_dc = 16'd1;

    // Fill to full, reject the ninth, drain in order
    rdy_allow = 1'b0;
    for (int i = 0; i < 8; i++) push(16'(i + 1), 16'(-(i + 1)), 1'(i));
    chk("t2_level_full", 64'(level), 64'(8));
    chk("t2_ready_full", 64'(cmd_ready), 64'(0));
    push(16'h0999, 16'h0001, 1'b1);
    chk("t2_level_rej", 64'(level), 64'(8));
    rdy_allow = 1'b1; resp_lat = 2;
    wait_idle("t2_idle", 500);
    chk("t2_ntrig", 64'(trig_log.size()), 64'(9));
    for (int i = 0; i < 8; i++) chk_trig(1 + i, mk(16'(i + 1), 16'(-(i + 1)), 1'(i)));
    exp_dc = 16'd9;
    chk("t2_dc", 64'(done_count), 64'(exp_dc));

    // Null moves after reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_dc = 16'd0;
    chk("t3_dc_rst", 64'(done_count), 64'(0));
    chk("t3_servo_rst", 64'(mot_servo_down), 64'(0));
    push(16'd0, 16'd0, 1'b0);
    tick(5);
    chk("t3_null_ntrig", 64'(trig_log.size()), 64'(9));
    chk("t3_null_dc", 64'(done_count), 64'(0));
    chk("t3_null_level", 64'(level), 64'(0));
    push(16'd0, 16'd0, 1'b1);
    wait_idle("t3_idle", 100);
    chk("t3_ntrig", 64'(trig_log.size()), 64'(10));
    chk_trig(9, mk(16'd0, 16'd0, 1'b1));
    exp_dc = 16'd1;
    chk("t3_dc", 64'(done_count), 64'(exp_dc));

    // Simultaneous pop and push, full and partly full
    resp_en = 1'b0; man_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push(16'(200 + i), 16'(i), 1'(i));
    chk("t4_level_full", 64'(level), 64'(8));
    chk("t4_ready_full", 64'(cmd_ready), 64'(0));
    cmd_pulse_x = 16'd999; man_rdy = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; man_rdy = 1'b0;
    chk("t4_level_7", 64'(level), 64'(7));
    chk("t4_trig", 64'(mot_trigger), 64'(1));
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (4) man_cycle();
    chk("t4_level_3a", 64'(level), 64'(3));
    cmd_pulse_x = 16'd555; cmd_pulse_y = 16'd0; cmd_servo_down = 1'b1;
    man_rdy = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; man_rdy = 1'b0;
    chk("t4_level_3b", 64'(level), 64'(3));
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    exp_dc = 16'd7;
    chk("t4_dc", 64'(done_count), 64'(exp_dc));
    for (int i = 0; i < 6; i++) chk_trig(10 + i, mk(16'(200 + i), 16'(i), 1'(i)));

    // Flush while a command is in WAIT_DONE
    push(16'd777, 16'd0, 1'b0);
    cmd_pulse_x = 16'd888; man_rdy = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; man_rdy = 1'b0;
    tick();
    chk("t5_level_4", 64'(level), 64'(4));
    chk("t5_trig_off", 64'(mot_trigger), 64'(0));
    cmd_pulse_x = 16'd444; cmd_valid = 1'b1; flush = 1'b1;
    tick();
    cmd_valid = 1'b0; flush = 1'b0;
    chk("t5_level_0", 64'(level), 64'(0));
    chk("t5_ready", 64'(cmd_ready), 64'(1));
    chk("t5_busy_wait", 64'(busy), 64'(1));
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    exp_dc = 16'd8;
    chk("t5_dc", 64'(done_count), 64'(exp_dc));
    chk("t5_busy", 64'(busy), 64'(0));
    man_rdy = 1'b1;
    tick(5);
    man_rdy = 1'b0;
    chk("t5_ntrig", 64'(trig_log.size()), 64'(17));
    chk_trig(16, mk(16'd206, 16'd6, 1'b0));

    // clk_en held low during ISSUE and during mot_done
    man_rdy = 1'b1;
    push(16'd321, 16'd7, 1'b0);
    tick();
    man_rdy = 1'b0;
    chk("t6_trig", 64'(mot_trigger), 64'(1));
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_trig_hold", 64'(mot_trigger), 64'(1));
    end
    clk_en = 1'b1;
    tick();
    chk("t6_trig_end", 64'(mot_trigger), 64'(0));
    clk_en = 1'b0; man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("t6_dc_gated", 64'(done_count), 64'(exp_dc));
    chk("t6_busy_gated", 64'(busy), 64'(1));
    clk_en = 1'b1; man_done = 1'b1;
    tick();
    man_done = 1'b0;
    exp_dc = 16'd9;
    chk("t6_dc", 64'(done_count), 64'(exp_dc));
    chk_trig(17, mk(16'd321, 16'd7, 1'b0));

    // Randomized traffic checked against the filtered command sequence
    trig_log.delete();
    resp_en = 1'b1; rdy_allow = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      clk_en         = ($urandom_range(0, 3) != 0);
      cmd_valid      = 1'($urandom_range(0, 1));
      cmd_pulse_x    = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
      cmd_pulse_y    = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
      cmd_servo_down = 1'($urandom_range(0, 1));
      resp_lat       = int'($urandom_range(1, 4));
      if (cmd_valid && cmd_ready && clk_en) mq.push_back(mk(cmd_pulse_x, cmd_pulse_y, cmd_servo_down));
      tick();
    end
    cmd_valid = 1'b0; clk_en = 1'b1;
    wait_idle("rand_drain", 2000);
    prev_s = 1'b0;
    foreach (mq[i]) begin
      rc = mq[i];
      if (!(rc.x == 16'd0 && rc.y == 16'd0 && rc.s == prev_s)) begin
        exp_q.push_back(rc);
        prev_s = rc.s;
      end
    end
    chk("rand_ntrig", 64'(trig_log.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) chk_trig(i, exp_q[i]);
    chk("rand_dc", 64'(done_count), 64'(16'(exp_dc + 16'(exp_q.size()))));
    chk("rand_servo", 64'(mot_servo_down), 64'(prev_s));
    chk("rand_level", 64'(level), 64'(0));
    chk("rand_ready", 64'(cmd_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
